// File: rtl/alu_arb_pkg.sv
// Shared opcodes, FSM encoding and counter width for the ALU request arbiter.
// sat_inc is a saturating step used by the optional grant counters.
package alu_arb_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int STAT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    function automatic logic [STAT_W-1:0] sat_inc(
        input logic [STAT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Ports: req, ptr in; one-hot gnt and its index gnt_idx out.
module rr_pick
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
)
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic found;

    // Walk distance k from ptr; the first requesting slot wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] &&
                    i == (int'(ptr) + k) % NUM_REQ) begin
                    found   = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sequencing NUM_REQ requesters onto one external ALU.
// Ports: req_* handshake in, resp_* handshake out, alu_* to/from the ALU,
// busy/gnt_id status. With ALU_ARB_STATS_EN defined, stat_cnt exposes
// saturating 8-bit per-requester grant counters.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]      req_op,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]         resp_data,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [1:0]                alu_op,
    output logic                      alu_en,
    input  logic [DATA_W-1:0]         alu_result,
    output logic                      busy,
    output logic [IDX_W-1:0]          gnt_id
`ifdef ALU_ARB_STATS_EN
   ,output logic [NUM_REQ*STAT_W-1:0] stat_cnt
`endif
);

    state_t              state;
    state_t              state_nx;
    logic [IDX_W-1:0]    ptr;
    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic [DATA_W-1:0]   lat_a;
    logic [DATA_W-1:0]   lat_b;
    logic [1:0]          lat_op;
    logic                accept;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        req_ready  = '0;
        resp_valid = '0;
        resp_data  = '0;
        alu_en     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (|req_valid) begin
                    accept    = 1'b1;
                    req_ready = pick_gnt;
                    state_nx  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_en   = 1'b1;
                state_nx = ST_RESP;
            end
            ST_RESP: begin
                resp_valid[gnt_id] = 1'b1;
                resp_data          = alu_result;
                if (resp_ready[gnt_id]) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            gnt_id <= '0;
            lat_a  <= '0;
            lat_b  <= '0;
            lat_op <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                lat_a  <= req_a[pick_idx*DATA_W +: DATA_W];
                lat_b  <= req_b[pick_idx*DATA_W +: DATA_W];
                lat_op <= req_op[pick_idx*2 +: 2];
                gnt_id <= pick_idx;
                // Winner drops to lowest priority for the next search.
                ptr    <= (pick_idx == IDX_W'(NUM_REQ-1)) ?
                          '0 : pick_idx + 1'b1;
            end
        end
    end

    assign busy   = (state != ST_IDLE);
    assign alu_a  = lat_a;
    assign alu_b  = lat_b;
    assign alu_op = lat_op;

`ifdef ALU_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        logic [STAT_W-1:0] cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (accept && pick_gnt[i]) begin
                cnt <= sat_inc(cnt);
            end
        end
        assign stat_cnt[i*STAT_W +: STAT_W] = cnt;
    end
`else
    // Grant counters are not built in this configuration.
`endif

endmodule
